// File: rtl/vga_sync.sv
// vga_sync: VGA raster timing generator (pixel divider, h/v counters, registered sync/enable decodes).
module vga_sync #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter int   CLK_DIV     = 2,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_tick,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       display_enable,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_sync: H_TOTAL/V_TOTAL must be <= 1024 and CLK_DIV >= 1");
    end

    logic [DW-1:0] div_cnt;
    logic          run;
    logic [9:0]    hc_n;
    logic [9:0]    vc_n;

    // run stays low through the first edge after release so that edge refreshes decodes only
    assign pix_tick = run && div_cnt == DIV_MAX;

    always_comb begin
        hc_n = hc;
        vc_n = vc;
        if (pix_tick) begin
            hc_n = hc == H_LAST ? 10'd0 : hc + 10'd1;
            if (hc == H_LAST)
                vc_n = vc == V_LAST ? 10'd0 : vc + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run            <= 1'b0;
            div_cnt        <= '0;
            hc             <= '0;
            vc             <= '0;
            display_enable <= 1'b0;
            hsync          <= ~SYNC_ACTIVE;
            vsync          <= ~SYNC_ACTIVE;
            line_start     <= 1'b0;
            frame_start    <= 1'b0;
        end else begin
            run            <= 1'b1;
            div_cnt        <= (pix_tick || !run) ? '0 : div_cnt + 1'b1;
            hc             <= hc_n;
            vc             <= vc_n;
            display_enable <= hc_n < H_VIS && vc_n < V_VIS;
            hsync          <= (hc_n >= HS_FIRST && hc_n <= HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync          <= (vc_n >= VS_FIRST && vc_n <= VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            line_start     <= hc_n == 10'd0;
            frame_start    <= hc_n == 10'd0 && vc_n == 10'd0;
        end
    end
endmodule
